cache_fill_fsm: RTL and testbench

- Miss-handling engine between the pipeline caches (I-side fetch, D-side memory stage) and the multi-cycle main memory.
- On a cache miss it stalls the requesting stage and issues one read per word of the missing block to a pipelined memory.
- Each returned word is written into the cache data array; the tag array is written on the final word.
- One instance per cache; arbitration between instances lives outside this block.

---
 rtl/cache_fill_if.sv | 33 +++
 rtl/cache_fill_fsm.sv | 82 ++++++++
 tb/tb_cache_fill_fsm.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_if.sv
// Miss-handling bus between a cache, its fill engine and main memory.
// The master modport is the fill engine; the slave modport is the cache/memory side.
`timescale 1ns/1ps
interface cache_fill_if #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
);
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [15:0]       memory_data;
  logic              fsm_busy;
  logic              mem_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [IDX_W-1:0]  fill_word;
  logic [15:0]       fill_data;
  logic              write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_en, memory_address, write_data_array, fill_word,
           fill_data, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_en, memory_address, write_data_array, fill_word,
           fill_data, write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: issues one pipelined read per block word and writes
// returned words into the data array, committing the tag with the final word.
`timescale 1ns/1ps
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_fill_if.master bus
);
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 1;  // byte offset bits of a block of 16-bit words
  localparam logic [CNT_W-1:0] ISSUE_DONE = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] LAST_WORD  = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {IDLE, FILL} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0]  recv_cnt_q, recv_cnt_d;
  logic [ADDR_W-1:0] base_addr_q, base_addr_d;

  logic              issuing;
  logic              receiving;
  logic              last_word;
  logic [IDX_W-1:0]  addr_idx;

  // A valid is only accepted for a word that has actually been requested.
  assign issuing   = (state_q == FILL) && (issue_cnt_q < ISSUE_DONE);
  assign receiving = (state_q == FILL) && bus.memory_data_valid
                     && ({1'b0, recv_cnt_q} < issue_cnt_q);
  assign last_word = receiving && (recv_cnt_q == LAST_WORD);
  assign addr_idx  = (issue_cnt_q < ISSUE_DONE) ? issue_cnt_q[IDX_W-1:0] : LAST_WORD;

  assign bus.fsm_busy         = (state_q == FILL);
  assign bus.mem_en           = issuing;
  assign bus.memory_address   = base_addr_q + ADDR_W'({addr_idx, 1'b0});
  assign bus.write_data_array = receiving;
  assign bus.fill_word        = recv_cnt_q;
  assign bus.fill_data        = receiving ? bus.memory_data : '0;
  assign bus.write_tag_array  = last_word;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    base_addr_d = base_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          base_addr_d = {bus.miss_address[ADDR_W-1:OFF_W], OFF_W'(0)};
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (issuing)   issue_cnt_d = issue_cnt_q + CNT_W'(1);
        if (receiving) recv_cnt_d  = recv_cnt_q + IDX_W'(1);
        if (last_word) state_d     = IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      base_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_addr_q <= base_addr_d;
    end
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: pipelined memory model, per-cycle
// reference model of the fill rules, table-driven fills and random fills.
`timescale 1ns/1ps
module tb_cache_fill_fsm;
  localparam int WPB = 8;
  localparam int AW  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_fill_if #(.WORDS_PER_BLOCK(WPB), .ADDR_W(AW)) bus ();
  cache_fill_fsm #(.WORDS_PER_BLOCK(WPB), .ADDR_W(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int          ready;
    logic [15:0] addr;
  } req_t;

  typedef struct {
    logic [15:0] addr;
    int          lat_min;
    int          lat_max;
    int          gap_pct;
    bit          toggle_miss;
    bit          hold;
    logic [15:0] next_addr;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_busy;
    int          exp_wr_off;
  } fill_vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // memory model state
  req_t memq[$];
  int   last_ready = 0;
  int   lat_min = 4, lat_max = 4, gap_pct = 0;
  bit   spurious_valid = 0;

  // reference model: what a fill must look like, in terms of words issued/received
  bit          m_busy   = 0;
  logic [15:0] m_base   = '0;
  int          m_issued = 0;
  int          m_recv   = 0;

  // per-fill statistics
  int          st_mem_en, st_writes, st_busy, st_tags, st_start, st_first_wr;
  bit          st_have_first;
  logic [15:0] st_first_addr, st_last_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fsm_busy"},         32'(bus.fsm_busy),         32'(0));
    check({tag, "_mem_en"},           32'(bus.mem_en),           32'(0));
    check({tag, "_memory_address"},   32'(bus.memory_address),   32'(0));
    check({tag, "_write_data_array"}, 32'(bus.write_data_array), 32'(0));
    check({tag, "_fill_word"},        32'(bus.fill_word),        32'(0));
    check({tag, "_fill_data"},        32'(bus.fill_data),        32'(0));
    check({tag, "_write_tag_array"},  32'(bus.write_tag_array),  32'(0));
  endtask

  task automatic clear_stats();
    st_mem_en = 0; st_writes = 0; st_busy = 0; st_tags = 0;
    st_start = cyc; st_first_wr = -1; st_have_first = 0;
    st_first_addr = '0; st_last_addr = '0;
  endtask

  // One clock cycle: entered and left at posedge+1; caller sets miss inputs first.
  task automatic step();
    logic [15:0] data;
    bit          v, exp_mem_en, exp_write, exp_last;
    int          ready;
    v = 1'b0;
    data = '0;
    if (spurious_valid) begin
      v = 1'b1;
      data = 16'($urandom);
    end else if (memq.size() > 0 && memq[0].ready <= cyc
                 && int'($urandom_range(99)) >= gap_pct) begin
      v = 1'b1;
      data = memq[0].addr;
      void'(memq.pop_front());
    end
    bus.memory_data_valid = v;
    bus.memory_data       = data;
    #1;
    exp_mem_en = m_busy && (m_issued < WPB);
    exp_write  = m_busy && v && (m_recv < m_issued);
    exp_last   = exp_write && (m_recv == WPB - 1);
    check("fsm_busy", 32'(bus.fsm_busy), 32'(m_busy));
    check("mem_en", 32'(bus.mem_en), 32'(exp_mem_en));
    if (exp_mem_en)
      check("memory_address", 32'(bus.memory_address), 32'(16'(32'(m_base) + 2 * m_issued)));
    check("write_data_array", 32'(bus.write_data_array), 32'(exp_write));
    if (exp_write) begin
      check("fill_word", 32'(bus.fill_word), 32'(m_recv));
      check("fill_data", 32'(bus.fill_data), 32'(16'(32'(m_base) + 2 * m_recv)));
    end
    check("write_tag_array", 32'(bus.write_tag_array), 32'(exp_last));

    if (bus.mem_en) begin
      ready = cyc + int'($urandom_range(lat_max, lat_min));
      if (ready <= last_ready) ready = last_ready + 1;
      last_ready = ready;
      memq.push_back('{ready: ready, addr: bus.memory_address});
      st_mem_en++;
      if (!st_have_first) begin st_first_addr = bus.memory_address; st_have_first = 1; end
      st_last_addr = bus.memory_address;
    end
    if (bus.fsm_busy) st_busy++;
    if (bus.write_data_array) begin
      st_writes++;
      if (st_first_wr < 0) st_first_wr = cyc - st_start;
    end
    if (bus.write_tag_array) st_tags++;

    if (!m_busy) begin
      if (bus.miss_detected) begin
        m_busy   = 1;
        m_base   = 16'(32'(bus.miss_address) - (32'(bus.miss_address) % (2 * WPB)));
        m_issued = 0;
        m_recv   = 0;
      end
    end else begin
      if (exp_mem_en) m_issued++;
      if (exp_write)  m_recv++;
      if (exp_last)   m_busy = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_fill(input fill_vec_t v);
    int budget;
    lat_min = v.lat_min;
    lat_max = v.lat_max;
    gap_pct = v.gap_pct;
    spurious_valid = 0;
    clear_stats();
    bus.miss_detected = 1'b1;
    bus.miss_address  = v.addr;
    step();
    check("accept_at_first_idle_edge", 32'(bus.fsm_busy), 32'(1));
    budget = 0;
    while (m_busy && budget < 300) begin
      if (v.hold) begin
        bus.miss_detected = 1'b1;
        bus.miss_address  = v.next_addr;
      end else if (v.toggle_miss) begin
        bus.miss_detected = 1'($urandom_range(1));
        bus.miss_address  = 16'($urandom);
      end else begin
        bus.miss_detected = 1'b0;
      end
      step();
      budget++;
    end
    check("fill_completes_in_budget", 32'(m_busy), 32'(0));
    if (!v.hold) bus.miss_detected = 1'b0;
    check("mem_en_cycles", 32'(st_mem_en), 32'(WPB));
    check("data_writes", 32'(st_writes), 32'(WPB));
    check("tag_writes", 32'(st_tags), 32'(1));
    check("first_read_addr", 32'(st_first_addr), 32'(v.exp_first));
    check("last_read_addr", 32'(st_last_addr), 32'(v.exp_last));
    if (v.exp_busy > 0)   check("busy_cycles", 32'(st_busy), 32'(v.exp_busy));
    if (v.exp_wr_off > 0) check("first_write_cycle", 32'(st_first_wr), 32'(v.exp_wr_off));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_vec_t tbl[5];
    fill_vec_t fv;
    int        budget;
    logic [15:0] a;

    // addr, lat_min, lat_max, gap%, toggle, hold, next, first, last, busy, first-write
    tbl[0] = '{16'h1236, 4, 4, 0,  1'b0, 1'b0, 16'h0000, 16'h1230, 16'h123E, 12, 5};
    tbl[1] = '{16'h2A51, 1, 6, 40, 1'b0, 1'b0, 16'h0000, 16'h2A50, 16'h2A5E, 0,  0};
    tbl[2] = '{16'h7777, 2, 5, 20, 1'b1, 1'b0, 16'h0000, 16'h7770, 16'h777E, 0,  0};
    tbl[3] = '{16'hFFFA, 3, 3, 0,  1'b0, 1'b1, 16'h0002, 16'hFFF0, 16'hFFFE, 11, 4};
    tbl[4] = '{16'h0002, 4, 4, 0,  1'b0, 1'b0, 16'h0000, 16'h0000, 16'h000E, 12, 5};

    rst_n = 1'b0;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'h5555;
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'hA5A5;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    bus.memory_data_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("after_reset");

    do_fill(tbl[0]);

    // memory_data_valid pulsed while idle must not write anything
    clear_stats();
    bus.miss_detected = 1'b0;
    spurious_valid = 1;
    repeat (3) step();
    spurious_valid = 0;
    check("idle_spurious_writes", 32'(st_writes), 32'(0));

    for (int i = 1; i < 5; i++) do_fill(tbl[i]);

    // asynchronous reset after the third word has been written
    lat_min = 2; lat_max = 2; gap_pct = 0;
    clear_stats();
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1000;
    step();
    bus.miss_detected = 1'b0;
    budget = 0;
    while (m_recv < 3 && budget < 50) begin
      step();
      budget++;
    end
    check("reached_third_word", 32'(m_recv), 32'(3));
    #3 rst_n = 1'b0;
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'hBEEF;
    #1;
    check_all_zero("async_reset");
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_no_tag", 32'(bus.write_tag_array), 32'(0));
      check("reset_not_busy", 32'(bus.fsm_busy), 32'(0));
    end
    check("no_tag_before_reset", 32'(st_tags), 32'(0));
    #2 rst_n = 1'b1;
    bus.memory_data_valid = 1'b0;
    memq.delete();
    m_busy = 0; m_issued = 0; m_recv = 0;
    @(posedge clk);
    #1;
    cyc += 4;
    check_all_zero("idle_after_midfill_reset");
    fv = '{16'h0040, 2, 4, 10, 1'b0, 1'b0, 16'h0000, 16'h0040, 16'h004E, 0, 0};
    do_fill(fv);

    // random fills checked against the reference model
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      fv.addr        = a;
      fv.lat_min     = int'($urandom_range(3, 1));
      fv.lat_max     = fv.lat_min + int'($urandom_range(3));
      fv.gap_pct     = int'($urandom_range(50));
      fv.toggle_miss = 1'($urandom_range(1));
      fv.hold        = 1'b0;
      fv.next_addr   = '0;
      fv.exp_first   = 16'(32'(a) - (32'(a) % 16));
      fv.exp_last    = 16'(32'(fv.exp_first) + 14);
      fv.exp_busy    = 0;
      fv.exp_wr_off  = 0;
      do_fill(fv);
      if ($urandom_range(1) == 1) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
